// File: rtl/supersonic.sv
// Ultrasonic echo-width ranger: measures the echo pulse and reports distance in um.
// Optional 2-flop input synchronizers enabled by SUPERSONIC_SYNC_EN.
`timescale 1ns/1ps
module supersonic #(
  parameter int unsigned SPEED_NUM      = 343,
  parameter int unsigned SPEED_DEN      = 100,
  parameter int unsigned TIMEOUT_CYCLES = 1_900_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger,
  input  logic        echo,
  output logic        valid,
  output logic [31:0] distance
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_ECHO,
    MEASURE,
    CALC,
    DONE
  } state_t;

  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] DIST_TO  = 32'hFFFF_FFFF;
  localparam logic [31:0] DIST_MAX = 32'hFFFF_FFFE;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] dist_d;
  logic        trigger_s, echo_s;
  logic [63:0] prod, quot;

`ifdef SUPERSONIC_SYNC_EN
  logic [1:0] trig_ff, echo_ff;

  // two-flop synchronizers for the sensor-side inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_ff <= '0;
      echo_ff <= '0;
    end else begin
      trig_ff <= {trig_ff[0], trigger};
      echo_ff <= {echo_ff[0], echo};
    end
  end

  assign trigger_s = trig_ff[1];
  assign echo_s    = echo_ff[1];
`else
  assign trigger_s = trigger;
  assign echo_s    = echo;
`endif

  // width to distance; wide product so large counts cannot wrap
  assign prod = 64'(cnt_q) * 64'(SPEED_NUM);
  assign quot = prod / 64'(SPEED_DEN);

  assign valid = (state_q == DONE);

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      timer_q  <= '0;
      distance <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      distance <= dist_d;
    end
  end

  // next-state and datapath updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    dist_d  = distance;
    unique case (state_q)
      IDLE: begin
        if (trigger_s) state_d = ARM;
      end
      ARM: begin
        if (!trigger_s) begin
          if (echo_s) begin
            state_d = MEASURE;
            cnt_d   = 32'd1;
          end else begin
            state_d = WAIT_ECHO;
            timer_d = '0;
          end
        end
      end
      WAIT_ECHO: begin
        if (echo_s) begin
          state_d = MEASURE;
          cnt_d   = 32'd1;
        end else begin
          timer_d = timer_q + 32'd1;
          if (timer_q >= TO_LAST) begin
            state_d = DONE;
            dist_d  = DIST_TO;
          end
        end
      end
      MEASURE: begin
        if (!echo_s) begin
          state_d = CALC;
        end else if (cnt_q >= TO_LAST) begin
          state_d = DONE;
          dist_d  = DIST_TO;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      CALC: begin
        state_d = DONE;
        if (quot > 64'(DIST_MAX)) dist_d = DIST_MAX;
        else                      dist_d = quot[31:0];
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_supersonic.sv
// Directed bench for supersonic: two instances, default-like ranger and a
// small-timeout / huge-factor one for timeout and saturation corners.
`timescale 1ns/1ps
module tb_supersonic;

`ifdef SUPERSONIC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  trig;
  logic [1:0]  ech;
  logic [1:0]  vld;
  logic [31:0] dist0, dist1;
  int          tests, fails;
  int          vc0, vc1;
  int          e, snap;

  supersonic #(
    .TIMEOUT_CYCLES(100000)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .trigger(trig[0]), .echo(ech[0]),
    .valid(vld[0]), .distance(dist0)
  );

  supersonic #(
    .SPEED_NUM(100_000_000),
    .SPEED_DEN(1),
    .TIMEOUT_CYCLES(100)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .trigger(trig[1]), .echo(ech[1]),
    .valid(vld[1]), .distance(dist1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (vld[0]) vc0++;
    if (vld[1]) vc1++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, obs, obs, exp, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic meas(input int d, input int tlen, input int gap,
                      input int w);
    @(negedge clk);
    trig[d] = 1'b1;
    repeat (tlen) @(negedge clk);
    trig[d] = 1'b0;
    repeat (gap) @(negedge clk);
    ech[d] = 1'b1;
    repeat (w) @(negedge clk);
    ech[d] = 1'b0;
  endtask

  task automatic wait_v(input int d, input int max, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!vld[d] && n < max);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    vc0   = 0;
    vc1   = 0;
    rst_n = 1'b0;
    trig  = '0;
    ech   = '0;
    #5;
    chk("reset_valid", 32'(vld[0]), 32'd0);
    chk("reset_dist", dist0, 32'd0);
    #19;
    rst_n = 1'b1;

    // long echo, 65535 samples
    snap = vc0;
    @(negedge clk);
    trig[0] = 1'b1;
    repeat (500) @(negedge clk);
    trig[0] = 1'b0;
    @(negedge clk);
    ech[0] = 1'b1;
    repeat (65535) @(negedge clk);
    ech[0] = 1'b0;
    wait_v(0, 20, e);
    chk("long_latency", 32'(e), 32'(2 + LAT));
    chk("long_dist", dist0, 32'd224785);
    repeat (5) @(negedge clk);
    chk("long_pulses", 32'(vc0 - snap), 32'd1);

    // 100-cycle echo after 20-cycle gap
    snap = vc0;
    meas(0, 10, 20, 100);
    wait_v(0, 20, e);
    chk("w100_latency", 32'(e), 32'(2 + LAT));
    chk("w100_dist", dist0, 32'd343);
    @(posedge clk);
    #1;
    chk("w100_one_cycle", 32'(vld[0]), 32'd0);
    repeat (3) @(negedge clk);
    chk("w100_pulses", 32'(vc0 - snap), 32'd1);

    // echo rises on the same cycle trigger falls
    meas(0, 10, 0, 200);
    wait_v(0, 20, e);
    chk("same_cyc_dist", dist0, 32'd686);
    repeat (3) @(negedge clk);

    // reset mid-measure
    @(negedge clk);
    trig[0] = 1'b1;
    repeat (10) @(negedge clk);
    trig[0] = 1'b0;
    @(negedge clk);
    ech[0] = 1'b1;
    repeat (30) @(negedge clk);
    snap = vc0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(vld[0]), 32'd0);
    chk("midrst_dist", dist0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    ech[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_valid", 32'(vc0 - snap), 32'd0);
    meas(0, 10, 3, 100);
    wait_v(0, 20, e);
    chk("after_rst_dist", dist0, 32'd343);
    repeat (3) @(negedge clk);

    // trigger re-pulsed during measure is ignored
    @(negedge clk);
    trig[0] = 1'b1;
    repeat (10) @(negedge clk);
    trig[0] = 1'b0;
    repeat (5) @(negedge clk);
    ech[0] = 1'b1;
    repeat (100) @(negedge clk);
    trig[0] = 1'b1;
    repeat (10) @(negedge clk);
    trig[0] = 1'b0;
    repeat (190) @(negedge clk);
    ech[0] = 1'b0;
    wait_v(0, 20, e);
    chk("retrig_dist", dist0, 32'd1029);
    repeat (5) @(negedge clk);

    // wait timeout on small instance
    @(negedge clk);
    trig[1] = 1'b1;
    repeat (10) @(negedge clk);
    trig[1] = 1'b0;
    wait_v(1, 300, e);
    chk("to_wait_edges", 32'(e), 32'(101 + LAT));
    chk("to_wait_dist", dist1, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);

    // saturation and width-timeout boundaries
    meas(1, 10, 1, 40);
    wait_v(1, 20, e);
    chk("w40_latency", 32'(e), 32'(2 + LAT));
    chk("w40_dist", dist1, 32'd4000000000);
    repeat (3) @(negedge clk);
    meas(1, 10, 1, 50);
    wait_v(1, 20, e);
    chk("w50_sat", dist1, 32'hFFFF_FFFE);
    repeat (3) @(negedge clk);
    meas(1, 10, 1, 99);
    wait_v(1, 20, e);
    chk("w99_sat", dist1, 32'hFFFF_FFFE);
    repeat (3) @(negedge clk);
    snap = vc1;
    meas(1, 10, 1, 100);
    repeat (10) @(negedge clk);
    chk("w100_to_pulses", 32'(vc1 - snap), 32'd1);
    chk("w100_to_dist", dist1, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
